async_fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter that lets `NUM_REQ` producers share the write side of one `async_fifo` instance, all in the `wr_clk` domain.
- Grants one requester at a time for a burst of up to `MAX_BURST` beats.
- Forwards the granted requester's data to the FIFO's `wr_en`/`wr_data` and back-pressures producers from the FIFO's `full`/`afull` flags.

---
 rtl/async_fifo_arb_pkg.sv | 39 +++
 rtl/rr_picker.sv | 28 ++
 rtl/async_fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_arb_pkg.sv
// rtl/async_fifo_arb_pkg.sv - state encoding and round-robin search helper for the FIFO write arbiter
// Contents:
//   IDLE_ENC / BURST_ENC : arbiter state encodings
//   arb_state_t          : arbiter FSM state type
//   rr_next_idx          : round-robin search; returns {found, index}
package async_fifo_arb_pkg;

    localparam logic IDLE_ENC  = 1'b0;
    localparam logic BURST_ENC = 1'b1;

    typedef enum logic {
        IDLE  = IDLE_ENC,
        BURST = BURST_ENC
    } arb_state_t;

    // Widest requester vector the search helper supports.
    localparam int RR_MAX_REQ = 16;

    // Searches req starting one past ptr and wrapping modulo num_req, so the
    // index at ptr itself is examined last. Result bit 4 is the found flag,
    // bits 3:0 the winning index.
    function automatic logic [4:0] rr_next_idx(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [3:0]            ptr,
        input int unsigned           num_req
    );
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            idx = 4'((32'(ptr) + k) % num_req);
            if (k <= num_req && !res[4] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
// Ports:
//   req       in  NUM_REQ : request vector
//   start_ptr in  IDX_W   : last winner; search begins at start_ptr+1
//   found     out 1       : at least one request set
//   win_idx   out IDX_W   : index of the first request found
module rr_picker
    import async_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   win_idx
);

    logic [4:0] res;

    always_comb begin
        res = rr_next_idx(RR_MAX_REQ'(req), 4'(start_ptr), NUM_REQ);
    end

    assign found   = res[4];
    assign win_idx = IDX_W'(res[3:0]);

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst arbiter sharing one async FIFO write port
// Optional feature macro: ASYNC_FIFO_WR_ARB_AFULL_THROTTLE_EN (new grants also wait for !fifo_afull)
// Ports:
//   wr_clk       in  1                  : write-domain clock
//   wr_rst       in  1                  : synchronous active-high reset
//   req_valid    in  NUM_REQ            : per-requester beat valid
//   req_data     in  NUM_REQ*DATA_WIDTH : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out NUM_REQ            : beat accepted this cycle (owner only)
//   fifo_full    in  1                  : FIFO full
//   fifo_afull   in  1                  : FIFO almost full
//   fifo_wr_en   out 1                  : FIFO write enable
//   fifo_wr_data out DATA_WIDTH         : FIFO write data
//   grant        out NUM_REQ            : registered one-hot owner, zero when idle
//   busy         out 1                  : registered, high while a burst is owned
module async_fifo_wr_arbiter
    import async_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_afull,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                start_ok;
    logic                in_burst;
    logic                owner_valid;
    logic                acc;
    logic                burst_end;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

`ifdef ASYNC_FIFO_WR_ARB_AFULL_THROTTLE_EN
    assign start_ok = !fifo_full && !fifo_afull;
`else
    logic unused_afull;
    assign unused_afull = fifo_afull;
    assign start_ok     = !fifo_full;
`endif

    assign in_burst    = (state_q == BURST);
    assign owner_valid = req_valid[grant_idx_q];
    // A beat never lands in a reset cycle, so the FIFO sees no write there.
    assign acc         = in_burst && owner_valid && !fifo_full && !wr_rst;
    assign burst_end   = in_burst && ((acc && (beat_cnt_q == LAST_BEAT)) || !owner_valid);

    // rr_ptr always holds the current/last owner, so the same picker serves
    // both the idle start and the zero-bubble hand-off with the owner last.
    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req       (req_valid),
        .start_ptr (rr_ptr_q),
        .found     (pick_found),
        .win_idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        if (!in_burst || burst_end) begin
            if (pick_found && start_ok) begin
                state_d     = BURST;
                grant_d     = NUM_REQ'(1) << pick_idx;
                grant_idx_d = pick_idx;
                rr_ptr_d    = pick_idx;
                beat_cnt_d  = '0;
            end else begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                req_ready[i] = acc;
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_wr_en = acc;
    assign grant      = grant_q;
    assign busy       = in_burst;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb/tb_async_fifo_wr_arbiter.sv - scoreboard bench for async_fifo_wr_arbiter
module tb_async_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 4;
    localparam int MB = 4;

    logic              wr_clk = 1'b0;
    logic              wr_rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_afull;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic [NR-1:0]     grant;
    logic              busy;

    always #5 wr_clk = ~wr_clk;

    async_fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_afull   (fifo_afull),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant        (grant),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic [DW-1:0] q3[$];

    int            exp_owner[$];
    logic [DW-1:0] exp_data[$];

    logic [NR-1:0] rdy_s = '0;
    int            mon_owner;
    logic [DW-1:0] mon_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Queue a beat at producer r and the write it must produce, in order.
    task automatic push_req(input int r, input logic [DW-1:0] d);
        case (r)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic push_exp(input int r, input logic [DW-1:0] d);
        exp_owner.push_back(r);
        exp_data.push_back(d);
    endtask

    task automatic drive_reqs();
        req_valid[0] = (q0.size() != 0);
        req_valid[1] = (q1.size() != 0);
        req_valid[2] = (q2.size() != 0);
        req_valid[3] = (q3.size() != 0);
        req_data[0*DW +: DW] = (q0.size() != 0) ? q0[0] : '0;
        req_data[1*DW +: DW] = (q1.size() != 0) ? q1[0] : '0;
        req_data[2*DW +: DW] = (q2.size() != 0) ? q2[0] : '0;
        req_data[3*DW +: DW] = (q3.size() != 0) ? q3[0] : '0;
    endtask

    task automatic next_cycle();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge wr_clk);
            if (!busy && grant == '0) done = 1'b1;
        end
        chk("wait_idle_in_budget", done, 1'b1);
    endtask

    task automatic pulse_reset();
        next_cycle();
        wr_rst = 1'b1;
        next_cycle();
        wr_rst = 1'b0;
        @(negedge wr_clk);
    endtask

    // Producers: hold valid/data until ready is seen, then advance.
    always @(negedge wr_clk) rdy_s <= req_ready;

    initial begin
        forever begin
            @(posedge wr_clk);
            #2;
            if (rdy_s[0] && q0.size() != 0) q0.delete(0);
            if (rdy_s[1] && q1.size() != 0) q1.delete(0);
            if (rdy_s[2] && q2.size() != 0) q2.delete(0);
            if (rdy_s[3] && q3.size() != 0) q3.delete(0);
            drive_reqs();
        end
    end

    // Scoreboard monitor: every FIFO write must be the next expected beat.
    always @(negedge wr_clk) begin
        if (fifo_wr_en === 1'b1) begin
            chk("no_write_while_full", fifo_full, 1'b0);
            if (exp_owner.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got write of %0h required no write", fifo_wr_data);
            end else begin
                mon_owner = exp_owner.pop_front();
                mon_data  = exp_data.pop_front();
                chk("wr_data", fifo_wr_data, mon_data);
                chk("wr_owner_grant", grant, 32'(1) << mon_owner);
                chk("wr_owner_ready", req_ready, 32'(1) << mon_owner);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int ord[5];
        ord = '{0, 1, 2, 3, 0};
        wr_rst     = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        fifo_afull = 1'b0;
        repeat (3) next_cycle();

        // Reset state
        @(negedge wr_clk);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_en", fifo_wr_en, 0);
        chk("reset_ready", req_ready, 0);

        // Single requester: 4 beats, alone re-grant, release, later re-grant
        next_cycle();
        wr_rst = 1'b0;
        push_req(0, 4'hA); push_req(0, 4'hB); push_req(0, 4'hC); push_req(0, 4'hD);
        push_exp(0, 4'hA); push_exp(0, 4'hB); push_exp(0, 4'hC); push_exp(0, 4'hD);
        @(negedge wr_clk);
        chk("t1_grant_latency", grant, 4'b0000);
        @(negedge wr_clk);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        repeat (3) @(negedge wr_clk);
        @(negedge wr_clk);
        chk("t1_alone_regrant", grant, 4'b0001);
        chk("t1_no_beat_invalid", fifo_wr_en, 1'b0);
        @(negedge wr_clk);
        chk("t1_released", grant, 4'b0000);
        chk("t1_released_busy", busy, 1'b0);
        push_req(0, 4'hE);
        push_exp(0, 4'hE);
        @(negedge wr_clk);
        chk("t1_regrant_latency", grant, 4'b0000);
        @(negedge wr_clk);
        chk("t1_regrant", grant, 4'b0001);
        wait_idle();

        // All four requesting: order 0,1,2,3,0 with no bubbles
        pulse_reset();
        for (int i = 0; i < 4; i++) push_req(0, 4'(i));
        for (int i = 0; i < 4; i++) push_req(0, 4'(12 + i));
        for (int i = 0; i < 4; i++) push_req(1, 4'(4 + i));
        for (int i = 0; i < 4; i++) push_req(2, 4'(8 + i));
        for (int i = 0; i < 4; i++) push_req(3, 4'(i ^ 5));
        for (int i = 0; i < 4; i++) push_exp(0, 4'(i));
        for (int i = 0; i < 4; i++) push_exp(1, 4'(4 + i));
        for (int i = 0; i < 4; i++) push_exp(2, 4'(8 + i));
        for (int i = 0; i < 4; i++) push_exp(3, 4'(i ^ 5));
        for (int i = 0; i < 4; i++) push_exp(0, 4'(12 + i));
        @(negedge wr_clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge wr_clk);
            chk("t2_rr_grant", grant, 32'(1) << ord[i/4]);
            chk("t2_no_bubble", fifo_wr_en, 1'b1);
        end
        wait_idle();

        // Requester 2 drops after 2 beats, requester 3 takes over
        push_req(2, 4'h1); push_req(2, 4'h2);
        for (int i = 0; i < 4; i++) push_req(3, 4'(3 + i));
        push_exp(2, 4'h1); push_exp(2, 4'h2);
        for (int i = 0; i < 4; i++) push_exp(3, 4'(3 + i));
        @(negedge wr_clk);
        @(negedge wr_clk);
        chk("t3_grant2", grant, 4'b0100);
        @(negedge wr_clk);
        @(negedge wr_clk);
        chk("t3_release_cycle", grant, 4'b0100);
        chk("t3_release_no_beat", fifo_wr_en, 1'b0);
        @(negedge wr_clk);
        chk("t3_grant3", grant, 4'b1000);
        wait_idle();

        // fifo_full stall for 5 cycles after 2 beats
        for (int i = 0; i < 4; i++) push_req(1, 4'(7 + i));
        for (int i = 0; i < 4; i++) push_exp(1, 4'(7 + i));
        @(negedge wr_clk);
        @(negedge wr_clk);
        chk("t4_grant1", grant, 4'b0010);
        @(negedge wr_clk);
        next_cycle();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            chk("t4_stall_wr_en", fifo_wr_en, 1'b0);
            chk("t4_stall_ready", req_ready, 4'b0000);
            chk("t4_stall_grant", grant, 4'b0010);
        end
        next_cycle();
        fifo_full = 1'b0;
        @(negedge wr_clk);
        chk("t4_resume_wr_en", fifo_wr_en, 1'b1);
        chk("t4_resume_grant", grant, 4'b0010);
        wait_idle();
        chk("t4_all_beats_written", exp_owner.size(), 0);

        // fifo_afull in IDLE with requester 1 pending
        next_cycle();
        fifo_afull = 1'b1;
        push_req(1, 4'hB); push_req(1, 4'hC);
        push_exp(1, 4'hB); push_exp(1, 4'hC);
`ifdef ASYNC_FIFO_WR_ARB_AFULL_THROTTLE_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            chk("t5_throttled_grant", grant, 4'b0000);
        end
        next_cycle();
        fifo_afull = 1'b0;
        @(negedge wr_clk);
        chk("t5_afull_fall_latency", grant, 4'b0000);
        @(negedge wr_clk);
        chk("t5_grant_after_afull", grant, 4'b0010);
`else
        @(negedge wr_clk);
        chk("t5_grant_latency", grant, 4'b0000);
        @(negedge wr_clk);
        chk("t5_afull_ignored", grant, 4'b0010);
        next_cycle();
        fifo_afull = 1'b0;
`endif
        wait_idle();

        // wr_rst during beat 2; requester 0 preferred afterwards
        for (int i = 0; i < 4; i++) push_req(2, 4'(1 + i));
        push_exp(2, 4'h1);
        for (int i = 0; i < 4; i++) push_exp(0, 4'(5 + i));
        for (int i = 1; i < 4; i++) push_exp(2, 4'(1 + i));
        @(negedge wr_clk);
        @(negedge wr_clk);
        chk("t6_grant2", grant, 4'b0100);
        next_cycle();
        wr_rst = 1'b1;
        for (int i = 0; i < 4; i++) push_req(0, 4'(5 + i));
        @(negedge wr_clk);
        chk("t6_no_write_in_reset", fifo_wr_en, 1'b0);
        chk("t6_no_ready_in_reset", req_ready, 4'b0000);
        next_cycle();
        wr_rst = 1'b0;
        @(negedge wr_clk);
        chk("t6_grant_after_reset", grant, 4'b0000);
        chk("t6_busy_after_reset", busy, 1'b0);
        @(negedge wr_clk);
        chk("t6_req0_preferred", grant, 4'b0001);
        wait_idle();
        chk("t6_scoreboard_drained", exp_owner.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
